// File: rtl/tof_range_poller.sv
// Periodic VL53L0X range poller: launches a 12-byte result-block read, drains the
// read FIFO and publishes range/status. Optional macro TOF_STATUS_CHECK_EN rejects bad status.
module tof_range_poller #(
  parameter int unsigned POLL_CYCLES    = 27000,
  parameter int unsigned TIMEOUT_CYCLES = 270000,
  parameter logic [6:0]  DEV_ADDR       = 7'h29,
  parameter logic [7:0]  RESULT_REG     = 8'h14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        rd_start,
  output logic [6:0]  rd_dev_address,
  output logic [7:0]  rd_reg_address,
  output logic [3:0]  rd_byte_width,
  input  logic        rd_done,
  input  logic        rd_failure,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  input  logic        fifo_valid,
  output logic [15:0] range_mm,
  output logic [3:0]  range_status,
  output logic        range_valid,
  output logic [7:0]  error_count,
  output logic        busy
);

  localparam logic [3:0] LastIdx     = 4'd11;
  localparam logic [3:0] StatusValid = 4'd11;

  typedef enum logic [2:0] {
    StIdle, StStart, StWait, StPop, StCapture, StPublish, StFlush, StError
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] poll_q, poll_d;
  logic [31:0] tmo_q, tmo_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  status_sh_q, status_sh_d;
  logic [7:0]  range_hi_q, range_hi_d;
  logic [15:0] range_mm_q, range_mm_d;
  logic [3:0]  range_status_q, range_status_d;
  logic        range_valid_q, range_valid_d;
  logic [7:0]  err_q, err_d;
  logic        flush_wait_q, flush_wait_d;
  logic        status_ok;
  logic [7:0]  err_inc;

`ifdef TOF_STATUS_CHECK_EN
  assign status_ok = (status_sh_q == StatusValid);
`else
  assign status_ok = 1'b1;
`endif

  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    poll_d         = poll_q;
    tmo_d          = tmo_q;
    idx_d          = idx_q;
    status_sh_d    = status_sh_q;
    range_hi_d     = range_hi_q;
    range_mm_d     = range_mm_q;
    range_status_d = range_status_q;
    range_valid_d  = 1'b0;
    err_d          = err_q;
    flush_wait_d   = flush_wait_q;
    rd_start       = 1'b0;
    fifo_rd_en     = 1'b0;

    case (state_q)
      StIdle: begin
        if (!enable) begin
          poll_d = '0;
        end else if (poll_q == POLL_CYCLES - 1) begin
          poll_d  = '0;
          state_d = StStart;
        end else begin
          poll_d = poll_q + 32'd1;
        end
      end
      StStart: begin
        rd_start = 1'b1;
        tmo_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (rd_failure) begin
          state_d = StError;
        end else if (rd_done) begin
          state_d = StPop;
        end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
          state_d = StError;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StPop: begin
        // The index never exceeds 11 here, so an empty FIFO is always a short read.
        if (fifo_empty) begin
          state_d = StError;
        end else begin
          fifo_rd_en = 1'b1;
          tmo_d      = '0;
          state_d    = StCapture;
        end
      end
      StCapture: begin
        if (fifo_valid) begin
          case (idx_q)
            4'd0:  status_sh_d = fifo_data[6:3];
            4'd10: range_hi_d  = fifo_data;
            4'd11: begin
              // Outputs load here so they are visible during the PUBLISH cycle.
              if (status_ok) begin
                range_mm_d     = {range_hi_q, fifo_data};
                range_status_d = status_sh_q;
                range_valid_d  = 1'b1;
              end
            end
            default: ;
          endcase
          idx_d   = idx_q + 4'd1;
          state_d = (idx_q == LastIdx) ? StPublish : StPop;
        end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
          state_d = StError;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StPublish: begin
        if (!status_ok) err_d = err_inc;
        idx_d        = '0;
        status_sh_d  = '0;
        range_hi_d   = '0;
        flush_wait_d = 1'b0;
        state_d      = StFlush;
      end
      StFlush: begin
        // Alternate pop / skip so only one pop is ever outstanding.
        if (flush_wait_q) begin
          flush_wait_d = 1'b0;
        end else if (fifo_empty) begin
          state_d = StIdle;
        end else begin
          fifo_rd_en   = 1'b1;
          flush_wait_d = 1'b1;
        end
      end
      StError: begin
        err_d        = err_inc;
        idx_d        = '0;
        status_sh_d  = '0;
        range_hi_d   = '0;
        flush_wait_d = 1'b0;
        state_d      = StFlush;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      poll_q         <= '0;
      tmo_q          <= '0;
      idx_q          <= '0;
      status_sh_q    <= '0;
      range_hi_q     <= '0;
      range_mm_q     <= '0;
      range_status_q <= '0;
      range_valid_q  <= 1'b0;
      err_q          <= '0;
      flush_wait_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      poll_q         <= poll_d;
      tmo_q          <= tmo_d;
      idx_q          <= idx_d;
      status_sh_q    <= status_sh_d;
      range_hi_q     <= range_hi_d;
      range_mm_q     <= range_mm_d;
      range_status_q <= range_status_d;
      range_valid_q  <= range_valid_d;
      err_q          <= err_d;
      flush_wait_q   <= flush_wait_d;
    end
  end

  assign rd_dev_address = DEV_ADDR;
  assign rd_reg_address = RESULT_REG;
  assign rd_byte_width  = 4'd12;
  assign range_mm       = range_mm_q;
  assign range_status   = range_status_q;
  assign range_valid    = range_valid_q;
  assign error_count    = err_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_tof_range_poller.sv
// Randomized self-checking bench for tof_range_poller with a behavioural read-stage/FIFO
// model and a transaction-level expectation model.
module tb_tof_range_poller;

  localparam int unsigned P = 16;
  localparam int unsigned T = 100;
  localparam int KDone = 0;
  localparam int KFail = 1;
  localparam int KTimeout = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_failure = 1'b0;
  logic        rd_start, fifo_rd_en, fifo_empty, range_valid, busy;
  logic        fifo_valid = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic [6:0]  rd_dev_address;
  logic [7:0]  rd_reg_address;
  logic [3:0]  rd_byte_width;
  logic [15:0] range_mm;
  logic [3:0]  range_status;
  logic [7:0]  error_count;

  always #5 clk = ~clk;

  tof_range_poller #(
    .POLL_CYCLES(P),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rd_start(rd_start), .rd_dev_address(rd_dev_address), .rd_reg_address(rd_reg_address),
    .rd_byte_width(rd_byte_width), .rd_done(rd_done), .rd_failure(rd_failure),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_valid(fifo_valid), .range_mm(range_mm), .range_status(range_status),
    .range_valid(range_valid), .error_count(error_count), .busy(busy)
  );

  // Read-stage result FIFO: bench pushes, DUT pops, data valid the cycle after a pop.
  logic [7:0]  fmem [0:255];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic        fifo_clr = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr     <= wr_ptr;
      fifo_valid <= 1'b0;
    end else begin
      fifo_valid <= fifo_rd_en && !fifo_empty;
      if (fifo_rd_en && !fifo_empty) begin
        fifo_data <= fmem[rd_ptr[7:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // Protocol watch: no pop while empty, never two pops back to back.
  int   viol = 0;
  logic rd_en_prev = 1'b0;
  always @(negedge clk) begin
    if (fifo_rd_en && (fifo_empty || rd_en_prev)) viol <= viol + 1;
    rd_en_prev <= fifo_rd_en;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model.
  int          m_err = 0;
  logic [15:0] m_range = '0;
  logic [3:0]  m_status = '0;
  logic [7:0]  txn_b [0:15];
  int          txn_n = 0;

  function automatic bit status_accepted(input logic [7:0] b0);
`ifdef TOF_STATUS_CHECK_EN
    return b0[6:3] == 4'd11;
`else
    return 1'b1;
`endif
  endfunction

  task automatic load_fifo();
    for (int i = 0; i < txn_n; i++) begin
      fmem[wr_ptr[7:0]] = txn_b[i];
      wr_ptr++;
    end
  endtask

  int          cyc_cnt = 0;
  int          rv_cnt = 0;
  int          rv_cyc = 0;
  logic [15:0] rv_mm = '0;
  logic [3:0]  rv_st = '0;

  task automatic tick();
    @(negedge clk);
    cyc_cnt++;
    if (range_valid === 1'b1) begin
      rv_cnt++;
      rv_cyc = cyc_cnt;
      rv_mm  = range_mm;
      rv_st  = range_status;
    end
  endtask

  // Returns at the negedge where rd_start is seen; expects it exactly P cycles on.
  task automatic wait_start();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rd_start !== 1'b1 && cyc < 4 * P + 10);
    check_eq("start_gap", 32'(cyc), 32'(P));
  endtask

  task automatic run_txn(input int kind, input bit also_done, input bit drop_en);
    bit exp_pub;
    int err_next;
    int guard;
    int seen;
    exp_pub  = (kind == KDone) && (txn_n >= 12) && status_accepted(txn_b[0]);
    err_next = exp_pub ? m_err : ((m_err < 255) ? m_err + 1 : 255);
    rv_cnt   = 0;
    cyc_cnt  = 0;
    tick();
    check_eq("start_one_cycle", 32'(rd_start), 32'd0);
    check_eq("busy_in_txn", 32'(busy), 32'd1);
    if (drop_en) enable = 1'b0;
    case (kind)
      KTimeout: begin
        repeat (T) tick();
        check_eq("tmo_not_early", 32'(error_count), 32'(m_err));
        tick();
        check_eq("tmo_error", 32'(error_count), 32'(err_next));
      end
      KFail: begin
        repeat ($urandom_range(0, 4)) tick();
        load_fifo();
        rd_failure = 1'b1;
        rd_done    = also_done;
        tick();
        rd_failure = 1'b0;
        rd_done    = 1'b0;
      end
      default: begin
        repeat ($urandom_range(0, 4)) tick();
        load_fifo();
        rd_done = 1'b1;
        cyc_cnt = 0;
        tick();
        rd_done = 1'b0;
      end
    endcase
    guard = 0;
    while (busy === 1'b1 && guard < 500) begin
      tick();
      guard++;
    end
    check_eq("busy_fall", 32'(busy), 32'd0);
    m_err = err_next;
    if (exp_pub) begin
      m_range  = {txn_b[10], txn_b[11]};
      m_status = txn_b[0][6:3];
    end
    check_eq("valid_pulses", 32'(rv_cnt), exp_pub ? 32'd1 : 32'd0);
    if (exp_pub) begin
      check_eq("valid_latency", 32'(rv_cyc), 32'd25);
      check_eq("pulse_range", 32'(rv_mm), 32'(m_range));
      check_eq("pulse_status", 32'(rv_st), 32'(m_status));
    end
    check_eq("error_count", 32'(error_count), 32'(m_err));
    check_eq("range_mm", 32'(range_mm), 32'(m_range));
    check_eq("range_status", 32'(range_status), 32'(m_status));
    check_eq("fifo_drained", 32'(fifo_empty), 32'd1);
    if (drop_en) begin
      seen = 0;
      repeat (P + 4) begin
        @(negedge clk);
        if (rd_start === 1'b1 || busy === 1'b1) seen++;
      end
      check_eq("idle_hold", 32'(seen), 32'd0);
      enable = 1'b1;
    end
    wait_start();
  endtask

  task automatic fill_random(input int n, input bit good_status);
    for (int i = 0; i < 16; i++) txn_b[i] = 8'($urandom);
    if (good_status) txn_b[0][6:3] = 4'd11;
    txn_n = n;
  endtask

  initial begin
    int seen;
    int r;
    repeat (3) @(negedge clk);
    check_eq("rst_rd_start", 32'(rd_start), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_range", 32'(range_mm), 32'd0);
    check_eq("rst_valid", 32'(range_valid), 32'd0);
    check_eq("rst_errors", 32'(error_count), 32'd0);
    check_eq("dev_addr", 32'(rd_dev_address), 32'h29);
    check_eq("reg_addr", 32'(rd_reg_address), 32'h14);
    check_eq("byte_width", 32'(rd_byte_width), 32'd12);
    reset = 1'b0;
    seen = 0;
    repeat (P + 4) begin
      @(negedge clk);
      if (rd_start === 1'b1 || busy === 1'b1) seen++;
    end
    check_eq("disabled_idle", 32'(seen), 32'd0);
    enable = 1'b1;
    wait_start();

    // Nominal read: status 11, range 300.
    for (int i = 0; i < 16; i++) txn_b[i] = 8'h00;
    txn_b[0] = 8'h58; txn_b[10] = 8'h01; txn_b[11] = 8'h2C; txn_n = 12;
    run_txn(KDone, 1'b0, 1'b0);
    check_eq("nominal_range", 32'(range_mm), 32'd300);
    check_eq("nominal_status", 32'(range_status), 32'd11);

    txn_n = 0;
    run_txn(KFail, 1'b0, 1'b0);
    check_eq("fail_errors", 32'(error_count), 32'd1);
    check_eq("fail_range_kept", 32'(range_mm), 32'd300);

    fill_random(5, 1'b1);
    run_txn(KDone, 1'b0, 1'b0);
    check_eq("short_errors", 32'(error_count), 32'd2);

    for (int i = 0; i < 16; i++) txn_b[i] = 8'h00;
    txn_b[0] = 8'h20; txn_b[10] = 8'h00; txn_b[11] = 8'h64; txn_n = 12;
    run_txn(KDone, 1'b0, 1'b0);
`ifdef TOF_STATUS_CHECK_EN
    check_eq("reject_errors", 32'(error_count), 32'd3);
    check_eq("reject_range_kept", 32'(range_mm), 32'd300);
`else
    check_eq("status4_value", 32'(range_status), 32'd4);
    check_eq("status4_range", 32'(range_mm), 32'd100);
`endif

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        fill_random(12 + $urandom_range(0, 3), $urandom_range(0, 3) != 0);
        run_txn(KDone, 1'b0, $urandom_range(0, 7) == 0);
      end else if (r <= 6) begin
        fill_random($urandom_range(0, 11), 1'b1);
        run_txn(KDone, 1'b0, $urandom_range(0, 7) == 0);
      end else if (r <= 8) begin
        fill_random($urandom_range(0, 14), 1'b1);
        run_txn(KFail, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      end else begin
        txn_n = 0;
        run_txn(KTimeout, 1'b0, 1'b0);
      end
    end

    // Reset while capturing byte 6 of a good read.
    fill_random(12, 1'b1);
    tick();
    load_fifo();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    repeat (13) tick();
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_rd_start", 32'(rd_start), 32'd0);
    check_eq("mid_rst_pop", 32'(fifo_rd_en), 32'd0);
    check_eq("mid_rst_range", 32'(range_mm), 32'd0);
    check_eq("mid_rst_status", 32'(range_status), 32'd0);
    check_eq("mid_rst_valid", 32'(range_valid), 32'd0);
    check_eq("mid_rst_errors", 32'(error_count), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    fifo_clr = 1'b1;
    tick();
    reset    = 1'b0;
    fifo_clr = 1'b0;
    m_err    = 0;
    m_range  = '0;
    m_status = '0;
    wait_start();

    txn_n = 0;
    for (int k = 0; k < 300; k++) run_txn(KTimeout, 1'b0, 1'b0);
    check_eq("err_saturated", 32'(error_count), 32'hFF);

    check_eq("pop_protocol", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
